// File: rtl/uart_rx_frame_receiver.sv
// rtl/uart_rx_frame_receiver.sv - 8N1 UART receiver with baud counter, mid-bit sampling and error pulses
// Optional macro UART_RX_PARITY_EN switches the frame format to 8E1 and enables Parity_Err_Sig.
module uart_rx_frame_receiver #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic       RX_Done_Sig,
    output logic [7:0] RX_Data,
    output logic       Frame_Err_Sig,
    output logic       Parity_Err_Sig
);

    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam int CNT_W   = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             start_edge, sample_pt, bit_wrap;

    assign start_edge = rx_prev_q & ~rx_sync_q;
    assign sample_pt  = (bit_cnt_q == CNT_MID);
    assign bit_wrap   = (bit_cnt_q == CNT_MAX);

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign Parity_Err_Sig = perr_q;
`else
    assign Parity_Err_Sig = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (RX_En_Sig && start_edge) state_d = START;
            end
            START: begin
                if (sample_pt && rx_sync_q) state_d = IDLE;
                else if (bit_wrap)          state_d = DATA;
            end
            DATA: begin
                if (sample_pt) shift_d[bit_idx_q] = rx_sync_q;
                if (bit_wrap) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_pt && (rx_sync_q != ^shift_q)) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end else if (bit_wrap) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (sample_pt) begin
                    if (rx_sync_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        state_d = IDLE;
                        ferr_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Losing the enable mid-frame discards everything this frame would have reported.
        if (state_q != IDLE && !RX_En_Sig) begin
            state_d = IDLE;
            data_d  = data_q;
            done_d  = 1'b0;
            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
        if (state_d == IDLE || state_q == IDLE) begin
            bit_cnt_d = '0;
            bit_idx_d = 3'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX_Pin_In;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign RX_Done_Sig   = done_q;
    assign RX_Data       = data_q;
    assign Frame_Err_Sig = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// tb/tb_uart_rx_frame_receiver.sv - directed scoreboard bench for uart_rx_frame_receiver
module tb_uart_rx_frame_receiver;

    localparam int CF  = 1000000;
    localparam int BD  = 100000;
    localparam int BPS = 10;
`ifdef UART_RX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_Pin_In = 1'b1;
    logic       RX_En_Sig = 1'b0;
    logic       RX_Done_Sig;
    logic [7:0] RX_Data;
    logic       Frame_Err_Sig;
    logic       Parity_Err_Sig;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int exp_done = 0, exp_ferr = 0, exp_perr = 0;
    logic [7:0] sb[$];
    bit any_now;
    bit prev_any = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_frame_receiver #(.CLK_FREQ(CF), .BAUD(BD)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_Pin_In      (RX_Pin_In),
        .RX_En_Sig      (RX_En_Sig),
        .RX_Done_Sig    (RX_Done_Sig),
        .RX_Data        (RX_Data),
        .Frame_Err_Sig  (Frame_Err_Sig),
        .Parity_Err_Sig (Parity_Err_Sig)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        any_now = RX_Done_Sig | Frame_Err_Sig | Parity_Err_Sig;
        if (any_now) begin
            check("pulse_exclusive", 32'(RX_Done_Sig) + 32'(Frame_Err_Sig) + 32'(Parity_Err_Sig), 1);
            check("pulse_not_consecutive", 32'(prev_any), 0);
        end
        if (RX_Done_Sig) begin
            done_cnt++;
            check("scoreboard_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) check("rx_data_on_done", 32'(RX_Data), 32'(sb.pop_front()));
        end
        if (Frame_Err_Sig)  ferr_cnt++;
        if (Parity_Err_Sig) perr_cnt++;
        prev_any = any_now;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame; drop_slot/rst_slot name the bit slot (0 = start) at whose middle
    // the enable is dropped or a one-cycle reset is applied (-1 = never).
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input int drop_slot, input int rst_slot);
        logic v;
        for (int i = 0; i < NSLOT; i++) begin
            if (i == 0)              v = 1'b0;
            else if (i <= 8)         v = d[i-1];
            else if (i == NSLOT - 1) v = stop_b;
            else                     v = par_b;
            RX_Pin_In = v;
            for (int c = 0; c < BPS; c++) begin
                if (i == drop_slot && c == BPS / 2) RX_En_Sig = 1'b0;
                if (i == rst_slot && c == BPS / 2) RST = 1'b1;
                if (i == rst_slot && c == BPS / 2 + 1) RST = 1'b0;
                @(negedge CLK);
            end
        end
        RX_Pin_In = 1'b1;
    endtask

    initial begin
        idle(3);
        check("reset_done", 32'(RX_Done_Sig), 0);
        check("reset_data", 32'(RX_Data), 32'h00);
        check("reset_frame_err", 32'(Frame_Err_Sig), 0);
        check("reset_parity_err", 32'(Parity_Err_Sig), 0);
        RST = 1'b0;
        RX_En_Sig = 1'b1;
        idle(5);

        // Good frame 0xA5
        sb.push_back(8'hA5); exp_done++;
        send_frame(8'hA5, 1'b1, ^8'hA5, -1, -1);
        idle(20);
        check("t1_done_count", 32'(done_cnt), 32'(exp_done));
        check("t1_data", 32'(RX_Data), 32'hA5);
        check("t1_no_frame_err", 32'(ferr_cnt), 0);
        idle(30);
        check("t1_data_held", 32'(RX_Data), 32'hA5);

        // Bad stop bit on 0x3C
        exp_ferr++;
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, -1);
        idle(20);
        check("t3_frame_err_count", 32'(ferr_cnt), 32'(exp_ferr));
        check("t3_no_done", 32'(done_cnt), 32'(exp_done));
        check("t3_data_kept", 32'(RX_Data), 32'hA5);

        // False start: 3-clock glitch
        RX_Pin_In = 1'b0;
        idle(3);
        RX_Pin_In = 1'b1;
        idle(15);
        check("t2_no_done", 32'(done_cnt), 32'(exp_done));
        check("t2_state_idle", 32'(dut.state_q), 0);
        sb.push_back(8'h3C); exp_done++;
        send_frame(8'h3C, 1'b1, ^8'h3C, -1, -1);
        idle(20);
        check("t2_done_count", 32'(done_cnt), 32'(exp_done));
        check("t2_data", 32'(RX_Data), 32'h3C);

        // Enable dropped during data bit 3 of 0x77
        send_frame(8'h77, 1'b1, ^8'h77, 4, -1);
        idle(20);
        check("t4_no_done_disabled", 32'(done_cnt), 32'(exp_done));
        check("t4_no_err_disabled", 32'(ferr_cnt + perr_cnt), 32'(exp_ferr + exp_perr));
        RX_En_Sig = 1'b1;
        idle(10);
        sb.push_back(8'h5A); exp_done++;
        send_frame(8'h5A, 1'b1, ^8'h5A, -1, -1);
        idle(20);
        check("t4_done_count", 32'(done_cnt), 32'(exp_done));
        check("t4_data", 32'(RX_Data), 32'h5A);

        // Back-to-back frames
        sb.push_back(8'h01); sb.push_back(8'hFF); exp_done += 2;
        send_frame(8'h01, 1'b1, ^8'h01, -1, -1);
        send_frame(8'hFF, 1'b1, ^8'hFF, -1, -1);
        idle(20);
        check("t5_done_count", 32'(done_cnt), 32'(exp_done));
        check("t5_data", 32'(RX_Data), 32'hFF);

        // Reset during data bit 2 of a third frame
        send_frame(8'hFF, 1'b1, ^8'hFF, -1, 3);
        idle(20);
        check("t5_rst_no_done", 32'(done_cnt), 32'(exp_done));
        check("t5_rst_data", 32'(RX_Data), 32'h00);
        check("t5_rst_no_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
        check("t5_rst_state_idle", 32'(dut.state_q), 0);

`ifdef UART_RX_PARITY_EN
        exp_perr++;
        send_frame(8'h07, 1'b1, 1'b0, -1, -1);
        idle(20);
        check("t6_parity_err_count", 32'(perr_cnt), 32'(exp_perr));
        check("t6_parity_no_done", 32'(done_cnt), 32'(exp_done));
        check("t6_parity_data_kept", 32'(RX_Data), 32'h00);
        sb.push_back(8'h07); exp_done++;
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        idle(20);
        check("t6_done_count", 32'(done_cnt), 32'(exp_done));
        check("t6_data", 32'(RX_Data), 32'h07);
`else
        check("no_parity_err_pulses", 32'(perr_cnt), 0);
`endif

        check("final_frame_err_count", 32'(ferr_cnt), 32'(exp_ferr));
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
